simon_sequence_checker: RTL and testbench

//  Sequential successor to the combinational input verifier. Walks the stored Simon

---
 rtl/simon_sequence_checker.sv | 172 +++++++++++++++++
 tb/tb_simon_sequence_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequence_checker.sv
// Simon sequence checker: steps through the stored colour sequence one button press at a
// time and gives a one-cycle pass/fail verdict for each round.
// Optional feature: INPUT_TIMEOUT_EN builds a per-press timeout counter (TIMEOUT_CYC).
module simon_sequence_checker #(
   parameter int unsigned MAX_LEN     = 32,
   parameter int unsigned COLOR_W     = 3,
   parameter int unsigned N_BUTTONS   = 4,
   parameter int unsigned TIMEOUT_CYC = 1000,
   localparam int unsigned IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [IDX_W-1:0]           check_round,
   input  logic [MAX_LEN*COLOR_W-1:0] seq_data,
   input  logic [N_BUTTONS-1:0]       player_input,
   output logic                       busy,
   output logic                       pass,
   output logic                       fail,
   output logic                       timeout,
   output logic [IDX_W-1:0]           progress,
   output logic                       empty
);

   typedef enum logic [1:0] {StIdle, StWaitPress, StWaitRelease} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   round_q, round_d;
   logic [IDX_W-1:0]   progress_q, progress_d;
   logic               armed_q, armed_d;
   logic               busy_q, busy_d;
   logic               pass_q, pass_d;
   logic               fail_q, fail_d;
   logic               timeout_q, timeout_d;

   logic [COLOR_W-1:0]   entry;
   logic [N_BUTTONS-1:0] exp_onehot;
   logic                 press;
   logic                 multi_hot;
   logic                 match;
   logic                 timer_expired;

   // A zero-cycle timeout has no meaning.
   if (TIMEOUT_CYC == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   assign press     = |player_input;
   assign multi_hot = |(player_input & (player_input - N_BUTTONS'(1)));
   assign match     = (player_input == exp_onehot);
   assign empty     = ~press;

   // Expected one-hot button for the current entry; codes >= N_BUTTONS map to no button.
   always_comb begin
      entry      = seq_data[32'(progress_q) * COLOR_W +: COLOR_W];
      exp_onehot = '0;
      for (int unsigned k = 0; k < N_BUTTONS; k++) begin
         if (32'(entry) == k) exp_onehot[k] = 1'b1;
      end
   end

`ifdef INPUT_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timer_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // Press timer: cleared on each entry to WAIT_PRESS, counts while staying there.
   always_comb begin
      cnt_d = '0;
      if (state_q == StWaitPress && state_d == StWaitPress) cnt_d = cnt_q + CNT_W'(1);
   end

   // Press timer register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign timer_expired = 1'b0;
`endif

   // Next-state and verdict logic; verdict pulses default low every cycle.
   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      progress_d = progress_q;
      armed_d    = armed_q;
      busy_d     = busy_q;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      timeout_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               round_d    = (32'(check_round) >= MAX_LEN) ? IDX_W'(MAX_LEN - 1) : check_round;
               progress_d = '0;
               // Buttons held at start must be released before a press is judged.
               armed_d    = ~press;
               busy_d     = 1'b1;
               state_d    = StWaitPress;
            end
         end
         StWaitPress: begin
            if (armed_q && press) begin
               if (multi_hot || !match) begin
                  fail_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  state_d = StWaitRelease;
               end
            end else if (timer_expired) begin
               fail_d    = 1'b1;
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = StIdle;
            end else if (!press) begin
               armed_d = 1'b1;
            end
         end
         StWaitRelease: begin
            if (!press) begin
               if (progress_q == round_q) begin
                  pass_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  progress_d = progress_q + IDX_W'(1);
                  armed_d    = 1'b1;
                  state_d    = StWaitPress;
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // FSM state and registered outputs; reset aborts a round without any verdict.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         round_q    <= '0;
         progress_q <= '0;
         armed_q    <= 1'b0;
         busy_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         progress_q <= progress_d;
         armed_q    <= armed_d;
         busy_q     <= busy_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         timeout_q  <= timeout_d;
      end
   end

   assign busy     = busy_q;
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign timeout  = timeout_q;
   assign progress = progress_q;

endmodule

// File: tb/tb_simon_sequence_checker.sv
// Directed self-checking bench for simon_sequence_checker.
module tb_simon_sequence_checker;

   localparam int unsigned MAX_LEN     = 32;
   localparam int unsigned COLOR_W     = 3;
   localparam int unsigned N_BUTTONS   = 4;
   localparam int unsigned TIMEOUT_CYC = 8;
   localparam int unsigned IDX_W       = 5;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic                       start = 1'b0;
   logic [IDX_W-1:0]           check_round = '0;
   logic [MAX_LEN*COLOR_W-1:0] seq_data = '0;
   logic [N_BUTTONS-1:0]       player_input = '0;
   logic                       busy, pass, fail, timeout, empty;
   logic [IDX_W-1:0]           progress;

   int compared   = 0;
   int mismatched = 0;

   simon_sequence_checker #(
      .MAX_LEN    (MAX_LEN),
      .COLOR_W    (COLOR_W),
      .N_BUTTONS  (N_BUTTONS),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .check_round (check_round),
      .seq_data    (seq_data),
      .player_input(player_input),
      .busy        (busy),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .progress    (progress),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compares {busy, pass, fail, timeout}.
   task automatic chk_outs(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {busy, pass, fail, timeout};
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: {busy,pass,fail,timeout} observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_prog(input string tag, input logic [IDX_W-1:0] exp);
      compared++;
      assert (progress === exp) else begin
         mismatched++;
         $error("FAIL %s: progress observed %0d expected %0d", tag, progress, exp);
      end
   endtask

   task automatic chk_empty(input string tag, input logic exp);
      compared++;
      assert (empty === exp) else begin
         mismatched++;
         $error("FAIL %s: empty observed %b expected %b", tag, empty, exp);
      end
   endtask

   task automatic do_start(input logic [IDX_W-1:0] r);
      check_round = r;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic press_release(input logic [N_BUTTONS-1:0] btn);
      player_input = btn;
      tick();
      player_input = '0;
      tick();
   endtask

   initial begin
      logic [N_BUTTONS-1:0] seq_btn [4];
      seq_btn = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int i = 0; i < MAX_LEN; i++) seq_data[i*COLOR_W +: COLOR_W] = 3'(i % 4);

      // Reset state
      tick();
      tick();
      chk_outs("reset_outs", 4'b0000);
      chk_prog("reset_progress", 5'd0);
      chk_empty("reset_empty", 1'b1);
      reset = 1'b0;
      tick();

      // empty follows player_input combinationally
      player_input = 4'b0100;
      #1;
      chk_empty("empty_pressed", 1'b0);
      player_input = '0;
      #1;
      chk_empty("empty_released", 1'b1);

      // Round 0 full pass
      do_start(5'd0);
      chk_outs("r0_busy", 4'b1000);
      chk_prog("r0_progress", 5'd0);
      player_input = 4'b0001;
      tick();
      chk_outs("r0_held", 4'b1000);
      player_input = '0;
      tick();
      chk_outs("r0_pass", 4'b0100);
      tick();
      chk_outs("r0_pass_end", 4'b0000);

      // Round 3 full pass, with an ignored start pulse mid-round
      do_start(5'd3);
      chk_prog("r3_progress0", 5'd0);
      press_release(seq_btn[0]);
      chk_prog("r3_progress1", 5'd1);
      check_round = 5'd0;
      start       = 1'b1;
      tick();
      start       = 1'b0;
      check_round = 5'd3;
      chk_outs("r3_start_ignored", 4'b1000);
      chk_prog("r3_start_ignored_prog", 5'd1);
      press_release(seq_btn[1]);
      chk_prog("r3_progress2", 5'd2);
      chk_outs("r3_mid", 4'b1000);
      press_release(seq_btn[2]);
      chk_prog("r3_progress3", 5'd3);
      press_release(seq_btn[3]);
      chk_outs("r3_pass", 4'b0100);
      tick();
      chk_outs("r3_pass_end", 4'b0000);
      chk_prog("r3_progress_hold", 5'd3);

      // Wrong colour at entry 1
      do_start(5'd2);
      press_release(4'b0001);
      player_input = 4'b0100;
      tick();
      chk_outs("wrong_fail", 4'b0010);
      chk_prog("wrong_progress", 5'd1);
      player_input = '0;
      tick();
      chk_outs("wrong_fail_end", 4'b0000);

      // Multi-button press
      do_start(5'd1);
      player_input = 4'b0011;
      tick();
      chk_outs("multi_fail", 4'b0010);
      chk_prog("multi_progress", 5'd0);
      player_input = '0;
      tick();
      chk_outs("multi_fail_end", 4'b0000);

      // Button held through start is not judged until released and pressed again
      player_input = 4'b0001;
      do_start(5'd0);
      tick();
      chk_outs("held_wait", 4'b1000);
      player_input = '0;
      tick();
      chk_outs("held_release_no_verdict", 4'b1000);
      press_release(4'b0001);
      chk_outs("held_then_pass", 4'b0100);
      tick();

      // Entry code outside the button range never matches
      seq_data[2:0] = 3'd7;
      do_start(5'd0);
      player_input = 4'b1000;
      tick();
      chk_outs("bad_code_fail", 4'b0010);
      player_input = '0;
      tick();
      seq_data[2:0] = 3'd0;

      // Reset mid-round aborts silently
      do_start(5'd3);
      press_release(4'b0001);
      chk_prog("abort_progress1", 5'd1);
      player_input = 4'b0010;
      tick();
      reset = 1'b1;
      #1;
      chk_outs("abort_outs", 4'b0000);
      chk_prog("abort_progress", 5'd0);
      tick();
      reset        = 1'b0;
      player_input = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_outs("abort_quiet", 4'b0000);
      end

`ifdef INPUT_TIMEOUT_EN
      // No press for TIMEOUT_CYC cycles
      do_start(5'd0);
      repeat (TIMEOUT_CYC - 1) tick();
      chk_outs("to_before", 4'b1000);
      tick();
      chk_outs("to_fire", 4'b0011);
      tick();
      chk_outs("to_end", 4'b0000);
`else
      // Without the timer the checker waits indefinitely
      do_start(5'd0);
      repeat (100) tick();
      chk_outs("no_timeout", 4'b1000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
